// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: MEM-stage FSM encoding, datapath widths, ID-stage opcodes
// and the ID control bundle consumed by the MEM stage.
package cpu_defs;

  localparam int XLEN_DEF = 32;
  localparam int REG_W    = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting on dmem_ack; expired_o is high on the TIMEOUT-th cycle.
// Saturates at TIMEOUT-1 so a missed clear never wraps into a false non-expired state.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: accepts one EX result, runs a dmem req/ack for loads/stores, emits one WB beat.
// ALU ops beat 2 cycles after accept, memory ops 1 cycle after ack; EX is stalled outside IDLE.
module mem_access_unit
  import cpu_defs::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             reg_write,
  input  logic [REG_W-1:0] rd,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic             err
);

  state_e           state_q;
  ctrl_t            ctrl_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0]  alu_q;
  logic             dmem_req_q, dmem_we_q;
  logic [XLEN-1:0]  dmem_addr_q, dmem_wdata_q;
  logic             wb_valid_q, wb_reg_write_q, err_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;
  logic             tmo_expired;
  logic             xfer;

  assign ex_ready = (state_q == ST_IDLE);
  assign stall    = ~ex_ready;
  assign xfer     = ex_valid & ex_ready;

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err          = err_q;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != ST_WAIT),
    .enable_i  (state_q == ST_WAIT),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ctrl_q         <= '0;
      rd_q           <= '0;
      alu_q          <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            ctrl_q <= {mem_read, mem_write, mem_to_reg, reg_write};
            rd_q   <= rd;
            alu_q  <= alu_result;
            if (mem_read || mem_write) begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= mem_write;
              dmem_addr_q  <= alu_result;
              dmem_wdata_q <= store_data;
              state_q      <= ST_WAIT;
            end else begin
              wb_rd_q        <= rd;
              wb_data_q      <= alu_result;
              wb_reg_write_q <= reg_write & (rd != '0);
              state_q        <= ST_WB;
            end
          end
        end
        ST_WAIT: begin
          // An ack on the final counted cycle still completes the access normally.
          if (dmem_ack || tmo_expired) begin
            dmem_req_q     <= 1'b0;
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_data_q      <= (dmem_ack && ctrl_q.mem_to_reg && ctrl_q.mem_read) ? dmem_rdata : alu_q;
            wb_reg_write_q <= dmem_ack & ctrl_q.reg_write & ~ctrl_q.mem_write & (rd_q != '0);
            err_q          <= ~dmem_ack | (ctrl_q.mem_read & ctrl_q.mem_write);
            state_q        <= ST_WB;
          end
        end
        ST_WB: begin
          // Memory results beat on entry to WB; ALU results use WB as a staging cycle and beat on exit.
          wb_valid_q <= ~wb_valid_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic        mem_read, mem_write, mem_to_reg, reg_write;
  logic [4:0]  rd;
  logic [31:0] alu_result, store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, stall, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .rd(rd), .alu_result(alu_result), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .err(err)
  );

  // Presents one op in the current cycle (caller is at a negedge); returns at the negedge after transfer.
  task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] sd);
    int n = 0;
    while (ex_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_wait: ex_ready=%b after 50 cycles, expected 1", ex_ready);
    end
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw;
    rd = r; alu_result = a; store_data = sd; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: req=%b wbv=%b err=%b wbrw=%b, expected all 0", dmem_req, wb_valid, err, wb_reg_write); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h wbdata=%h wbrd=%0d, expected 0", dmem_addr, dmem_wdata, wb_data, wb_rd); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ex_ready !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_ready: ex_ready=%b stall=%b, expected 1/0", ex_ready, stall); end
  endtask

  task automatic test_alu();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
    checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b0 || stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL alu_n1: wbv=%b rdy=%b stall=%b req=%b, expected 0/0/1/0", wb_valid, ex_ready, stall, dmem_req); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL alu_n2_valid: wbv=%b req=%b, expected 1/0", wb_valid, dmem_req); end
    checks++; if (wb_rd !== 5'd5 || wb_data !== 32'h1234 || wb_reg_write !== 1'b1) begin
      errors++; $display("FAIL alu_n2_data: rd=%0d data=%h rw=%b, expected 5/00001234/1", wb_rd, wb_data, wb_reg_write); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_single_beat: wbv=%b, expected 0", wb_valid); end
  endtask

  task automatic test_load();
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL load_req_c%0d: req=%b we=%b addr=%h wbv=%b, expected 1/0/100/0", i, dmem_req, dmem_we, dmem_addr, wb_valid); end
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      @(negedge clk);
    end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++; if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL load_wb: wbv=%b req=%b err=%b, expected 1/0/0", wb_valid, dmem_req, err); end
    checks++; if (wb_data !== 32'hDEADBEEF || wb_reg_write !== 1'b1 || wb_rd !== 5'd7) begin
      errors++; $display("FAIL load_data: data=%h rw=%b rd=%0d, expected deadbeef/1/7", wb_data, wb_reg_write, wb_rd); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL load_done: wbv=%b rdy=%b, expected 0/1", wb_valid, ex_ready); end
  endtask

  task automatic test_store();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h40, 32'hA5A5);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h40 || dmem_wdata !== 32'hA5A5) begin
      errors++; $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h, expected 1/1/40/a5a5", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || err !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL store_wb: wbv=%b rw=%b err=%b req=%b, expected 1/0/0/0", wb_valid, wb_reg_write, err, dmem_req); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int n = 0;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h200, 32'h0);
    while (wb_valid !== 1'b1 && n < 40) begin
      if (dmem_req === 1'b1) req_cycles++;
      @(negedge clk);
      n++;
    end
    checks++; if (req_cycles != 16) begin
      errors++; $display("FAIL timeout_req_cycles: %0d req cycles, expected 16", req_cycles); end
    checks++; if (wb_valid !== 1'b1 || err !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_wb: wbv=%b err=%b rw=%b req=%b, expected 1/1/0/0", wb_valid, err, wb_reg_write, dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'h99;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL late_ack_1: wbv=%b err=%b rdy=%b, expected 0/0/1", wb_valid, err, ex_ready); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL late_ack_2: wbv=%b err=%b req=%b, expected 0/0/0", wb_valid, err, dmem_req); end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_rd_zero_and_illegal();
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h10, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h55;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h55) begin
      errors++; $display("FAIL load_rd0: wbv=%b rw=%b data=%h, expected 1/0/55", wb_valid, wb_reg_write, wb_data); end
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h80, 32'h77);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h77 || dmem_addr !== 32'h80) begin
      errors++; $display("FAIL illegal_req: req=%b we=%b wdata=%h addr=%h, expected 1/1/77/80", dmem_req, dmem_we, dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || err !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL illegal_wb: wbv=%b err=%b rw=%b, expected 1/1/0", wb_valid, err, wb_reg_write); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL illegal_err_pulse: err=%b, expected 0", err); end
  endtask

  task automatic test_back_to_back();
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b1;
    rd = 5'd1; alu_result = 32'h11; ex_valid = 1'b1;
    @(negedge clk);
    checks++; if (ex_ready !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_stall: rdy=%b stall=%b, expected 0/1", ex_ready, stall); end
    rd = 5'd2; alu_result = 32'h22;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h11 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: wbv=%b rd=%0d data=%h rdy=%b, expected 1/1/11/1", wb_valid, wb_rd, wb_data, ex_ready); end
    @(negedge clk);
    ex_valid = 1'b0; reg_write = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: wbv=%b, expected 0", wb_valid); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h22) begin
      errors++; $display("FAIL b2b_second: wbv=%b rd=%0d data=%h, expected 1/2/22", wb_valid, wb_rd, wb_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    logic seen_wb = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h300, 32'h0);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_req: req=%b, expected 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_drop: req=%b rdy=%b, expected 0/1", dmem_req, ex_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_valid === 1'b1 || dmem_req === 1'b1) seen_wb = 1'b1;
    end
    checks++; if (seen_wb !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_wb: activity=%b after reset, expected 0", seen_wb); end
    issue(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hCAFE, 32'h0);
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE || wb_rd !== 5'd12 || wb_reg_write !== 1'b1) begin
      errors++; $display("FAIL rst_mid_next_op: wbv=%b data=%h rd=%0d rw=%b, expected 1/cafe/12/1", wb_valid, wb_data, wb_rd, wb_reg_write); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    rd = 5'd0; alu_result = 32'h0; store_data = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_rd_zero_and_illegal();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
